// File: rtl/rvv_issue_buffer.sv
// In-order issue buffer between the scalar core's vector issue port and the decoder.
// Optional zero-latency bypass when the queue is empty: define RVV_ISSUE_BYPASS_EN.
module rvv_issue_buffer #(
   parameter int unsigned Depth       = 4,
   parameter int unsigned MaxInflight = 8,
   parameter type         insn_id_t     = logic [3:0],
   parameter type         xlen_t        = logic [63:0],
   parameter type         vec_context_t = logic [15:0]
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               valid_i,
   output logic                               ready_o,
   input  logic [31:0]                        insn_i,
   input  logic [$bits(insn_id_t)-1:0]        insn_id_i,
   input  logic [$bits(xlen_t)-1:0]           scalar_reg_i,
   input  logic [$bits(vec_context_t)-1:0]    vec_context_i,
   input  logic                               flush_i,
   output logic                               out_valid_o,
   input  logic                               out_ready_i,
   output logic [31:0]                        out_insn_o,
   output logic [$bits(insn_id_t)-1:0]        out_id_o,
   output logic [$bits(xlen_t)-1:0]           out_scalar_o,
   output logic [$bits(vec_context_t)-1:0]    out_context_o,
   input  logic                               done_i,
   output logic [$clog2(Depth):0]             count_o,
   output logic [$clog2(MaxInflight):0]       inflight_o,
   output logic                               err_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned InfW = $clog2(MaxInflight) + 1;

   typedef struct packed {
      logic [31:0]                     insn;
      logic [$bits(insn_id_t)-1:0]     id;
      logic [$bits(xlen_t)-1:0]        scalar;
      logic [$bits(vec_context_t)-1:0] ctx;
   } entry_t;

   entry_t            mem_q [Depth];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [InfW-1:0]   inflight_q, inflight_d;
   logic              err_q, err_d;

   entry_t            in_entry;
   entry_t            head_entry;
   entry_t            out_entry;
   logic              bypass;
   logic              enq;
   logic              deq;
   logic              disp;

   assign in_entry   = '{insn: insn_i, id: insn_id_i, scalar: scalar_reg_i, ctx: vec_context_i};
   assign head_entry = mem_q[rd_ptr_q];

   // Capacity counts queued entries plus those already handed to the decoder.
   assign ready_o = !flush_i
                 && (32'(count_q) < Depth)
                 && ((32'(count_q) + 32'(inflight_q)) < MaxInflight);

`ifdef RVV_ISSUE_BYPASS_EN
   assign bypass = (count_q == '0) && valid_i && out_ready_i && ready_o && !flush_i;
`else
   assign bypass = 1'b0;
`endif

   assign out_valid_o = (!flush_i && (count_q != '0)) || bypass;
   assign out_entry   = bypass ? in_entry : head_entry;

   assign out_insn_o    = out_entry.insn;
   assign out_id_o      = out_entry.id;
   assign out_scalar_o  = out_entry.scalar;
   assign out_context_o = out_entry.ctx;

   // A bypassed instruction is dispatched without touching storage.
   assign disp = out_valid_o && out_ready_i;
   assign enq  = valid_i && ready_o && !bypass;
   assign deq  = disp && !bypass;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (deq) rd_ptr_d = rd_ptr_q + PtrW'(1);
         unique case ({enq, deq})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_comb begin
      inflight_d = inflight_q;
      err_d      = err_q;
      unique case ({disp, done_i})
         2'b10: inflight_d = inflight_q + InfW'(1);
         2'b01: begin
            if (inflight_q == '0) err_d = 1'b1;
            else                  inflight_d = inflight_q - InfW'(1);
         end
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   // Payload storage carries no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk_i) begin
      if (enq) mem_q[wr_ptr_q] <= in_entry;
   end

   assign count_o    = count_q;
   assign inflight_o = inflight_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_rvv_issue_buffer.sv
// Scoreboard bench for rvv_issue_buffer (Depth=4, MaxInflight=8).
module tb_rvv_issue_buffer;

   logic         clk;
   logic         rst_n;
   logic         valid;
   logic         ready_o;
   logic [31:0]  insn;
   logic [3:0]   id;
   logic [63:0]  scalar;
   logic [15:0]  ctx;
   logic         flush;
   logic         out_valid_o;
   logic         out_ready;
   logic [31:0]  out_insn_o;
   logic [3:0]   out_id_o;
   logic [63:0]  out_scalar_o;
   logic [15:0]  out_context_o;
   logic         done;
   logic [2:0]   count_o;
   logic [3:0]   inflight_o;
   logic         err_o;

   logic [115:0] sb[$];
   logic         acc;
   logic [3:0]   next_id;
   int           vecs;
   int           fails;

   rvv_issue_buffer dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .valid_i       (valid),
      .ready_o       (ready_o),
      .insn_i        (insn),
      .insn_id_i     (id),
      .scalar_reg_i  (scalar),
      .vec_context_i (ctx),
      .flush_i       (flush),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready),
      .out_insn_o    (out_insn_o),
      .out_id_o      (out_id_o),
      .out_scalar_o  (out_scalar_o),
      .out_context_o (out_context_o),
      .done_i        (done),
      .count_o       (count_o),
      .inflight_o    (inflight_o),
      .err_o         (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_in(input logic v, input logic [3:0] i);
      valid  = v;
      id     = i;
      insn   = {i, 28'hC0FFEE0};
      scalar = {60'h123456789ABCDEF, i};
      ctx    = {12'hA5A, i};
   endtask

   // One clock: sample handshakes at the falling edge, then advance past the rising edge.
   task automatic step();
      logic [115:0] exp;
      @(negedge clk);
      acc = valid && ready_o;
      if (acc) sb.push_back({insn, id, scalar, ctx});
      if (out_valid_o && out_ready) begin
         vecs++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL dispatch_order: got id %0d, required nothing pending", out_id_o);
         end else begin
            exp = sb.pop_front();
            if ({out_insn_o, out_id_o, out_scalar_o, out_context_o} !== exp) begin
               fails++;
               $display("FAIL dispatch_order: got %h, required %h",
                        {out_insn_o, out_id_o, out_scalar_o, out_context_o}, exp);
            end
         end
      end
      if (flush) sb.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; done = 1'b0;
      drive_in(1'b0, 4'd0);
      #2;
      vecs++; if (count_o !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d, required 0", count_o); end
      vecs++; if (inflight_o !== 4'd0) begin fails++; $display("FAIL reset_inflight: got %0d, required 0", inflight_o); end
      vecs++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b, required 0", err_o); end
      vecs++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, required 0", out_valid_o); end
      vecs++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b, required 1", ready_o); end
      flush = 1'b1; #1;
      vecs++; if (ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready_flush: got %b, required 0", ready_o); end
      flush = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_fill_drain();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_in(1'b1, 4'(i));
         step();
      end
      drive_in(1'b0, 4'd0); #1;
      vecs++; if (count_o !== 3'd4) begin fails++; $display("FAIL fill_count: got %0d, required 4", count_o); end
      vecs++; if (ready_o !== 1'b0) begin fails++; $display("FAIL fill_ready: got %b, required 0", ready_o); end
      vecs++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd0) begin fails++; $display("FAIL fill_head: got valid %b id %0d, required valid 1 id 0", out_valid_o, out_id_o); end
      step();
      vecs++; if (out_id_o !== 4'd0 || out_insn_o !== 32'h0C0FFEE0) begin fails++; $display("FAIL fill_head_hold: got id %0d insn %h, required id 0 insn 0c0ffee0", out_id_o, out_insn_o); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         vecs++; if (out_valid_o !== 1'b1 || out_id_o !== 4'(i)) begin fails++; $display("FAIL drain_id: got valid %b id %0d, required valid 1 id %0d", out_valid_o, out_id_o, i); end
         step();
      end
      out_ready = 1'b0; #1;
      vecs++; if (count_o !== 3'd0) begin fails++; $display("FAIL drain_count: got %0d, required 0", count_o); end
      vecs++; if (inflight_o !== 4'd4) begin fails++; $display("FAIL drain_inflight: got %0d, required 4", inflight_o); end
      vecs++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL drain_out_valid: got %b, required 0", out_valid_o); end
      done = 1'b1;
      for (int i = 0; i < 4; i++) step();
      done = 1'b0;
      vecs++; if (inflight_o !== 4'd0) begin fails++; $display("FAIL drain_retire: got %0d, required 0", inflight_o); end
   endtask

   task automatic test_inflight_limit();
      int steps;
      int exp_steps;
`ifdef RVV_ISSUE_BYPASS_EN
      exp_steps = 8;
`else
      exp_steps = 9;
`endif
      steps = 0; next_id = 4'd0; out_ready = 1'b1;
      while (inflight_o !== 4'd8 && steps < 30) begin
         drive_in(1'b1, next_id);
         step();
         if (acc) next_id = next_id + 4'd1;
         steps++;
      end
      drive_in(1'b0, 4'd0); #1;
      vecs++; if (steps != exp_steps) begin fails++; $display("FAIL limit_cycles: got %0d, required %0d", steps, exp_steps); end
      vecs++; if (inflight_o !== 4'd8) begin fails++; $display("FAIL limit_inflight: got %0d, required 8", inflight_o); end
      vecs++; if (ready_o !== 1'b0) begin fails++; $display("FAIL limit_ready: got %b, required 0", ready_o); end
      vecs++; if (next_id !== 4'd8) begin fails++; $display("FAIL limit_accepted: got %0d, required 8", next_id); end
      done = 1'b1; #1;
      vecs++; if (ready_o !== 1'b0) begin fails++; $display("FAIL limit_ready_done_cycle: got %b, required 0", ready_o); end
      step();
      done = 1'b0; #1;
      vecs++; if (ready_o !== 1'b1) begin fails++; $display("FAIL limit_ready_after_done: got %b, required 1", ready_o); end
      vecs++; if (inflight_o !== 4'd7) begin fails++; $display("FAIL limit_inflight_after_done: got %0d, required 7", inflight_o); end
      done = 1'b1;
      for (int i = 0; i < 7; i++) step();
      done = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin drive_in(1'b1, 4'(9 + i)); step(); end
      drive_in(1'b0, 4'd0); out_ready = 1'b1;
      for (int i = 0; i < 2; i++) step();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin drive_in(1'b1, 4'(12 + i)); step(); end
      drive_in(1'b0, 4'd0); #1;
      vecs++; if (count_o !== 3'd3 || inflight_o !== 4'd2) begin fails++; $display("FAIL flush_setup: got count %0d inflight %0d, required 3 and 2", count_o, inflight_o); end
      flush = 1'b1; done = 1'b1; out_ready = 1'b1; drive_in(1'b1, 4'd15); #1;
      vecs++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL flush_out_valid: got %b, required 0", out_valid_o); end
      vecs++; if (ready_o !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b, required 0", ready_o); end
      step();
      flush = 1'b0; done = 1'b0; drive_in(1'b0, 4'd0); #1;
      vecs++; if (count_o !== 3'd0) begin fails++; $display("FAIL flush_count: got %0d, required 0", count_o); end
      vecs++; if (inflight_o !== 4'd1) begin fails++; $display("FAIL flush_inflight: got %0d, required 1", inflight_o); end
      vecs++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL flush_empty: got %b, required 0", out_valid_o); end
      done = 1'b1; step(); done = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_simultaneous();
      int n;
      int guard;
      n = 0; guard = 0; out_ready = 1'b1;
      while (n < 3 && guard < 10) begin
         drive_in(1'b1, 4'(n + 1));
         step();
         if (acc) n++;
         guard++;
      end
      drive_in(1'b0, 4'd0);
      guard = 0;
      while (count_o !== 3'd0 && guard < 5) begin step(); guard++; end
      vecs++; if (inflight_o !== 4'd3) begin fails++; $display("FAIL simul_setup: got inflight %0d, required 3", inflight_o); end
      out_ready = 1'b0; drive_in(1'b1, 4'd7); step();
      drive_in(1'b0, 4'd0); out_ready = 1'b1; done = 1'b1; step();
      done = 1'b0; out_ready = 1'b0; #1;
      vecs++; if (inflight_o !== 4'd3) begin fails++; $display("FAIL simul_disp_done: got %0d, required 3", inflight_o); end
      for (int i = 0; i < 2; i++) begin drive_in(1'b1, 4'(i)); step(); end
      out_ready = 1'b1; done = 1'b1; next_id = 4'd2;
      for (int i = 0; i < 10; i++) begin
         drive_in(1'b1, next_id);
         step();
         next_id = next_id + 4'd1;
         vecs++; if (count_o !== 3'd2 || inflight_o !== 4'd3) begin fails++; $display("FAIL simul_enq_deq: got count %0d inflight %0d, required 2 and 3", count_o, inflight_o); end
      end
      drive_in(1'b0, 4'd0); done = 1'b0;
      for (int i = 0; i < 2; i++) step();
      out_ready = 1'b0; #1;
      vecs++; if (count_o !== 3'd0 || inflight_o !== 4'd5) begin fails++; $display("FAIL simul_drain: got count %0d inflight %0d, required 0 and 5", count_o, inflight_o); end
      done = 1'b1;
      for (int i = 0; i < 5; i++) step();
      done = 1'b0;
   endtask

   task automatic test_underflow();
      vecs++; if (inflight_o !== 4'd0 || err_o !== 1'b0) begin fails++; $display("FAIL underflow_setup: got inflight %0d err %b, required 0 and 0", inflight_o, err_o); end
      done = 1'b1; step(); done = 1'b0;
      vecs++; if (err_o !== 1'b1) begin fails++; $display("FAIL underflow_err: got %b, required 1", err_o); end
      vecs++; if (inflight_o !== 4'd0) begin fails++; $display("FAIL underflow_inflight: got %0d, required 0", inflight_o); end
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin drive_in(1'b1, 4'(i)); step(); end
      drive_in(1'b0, 4'd0);
      vecs++; if (err_o !== 1'b1) begin fails++; $display("FAIL underflow_sticky: got %b, required 1", err_o); end
      rst_n = 1'b0; #1;
      vecs++; if (err_o !== 1'b0 || count_o !== 3'd0 || out_valid_o !== 1'b0) begin fails++; $display("FAIL midrun_reset: got err %b count %0d out_valid %b, required 0 0 0", err_o, count_o, out_valid_o); end
      sb.delete();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_bypass();
      out_ready = 1'b1; drive_in(1'b1, 4'd5); #1;
`ifdef RVV_ISSUE_BYPASS_EN
      vecs++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd5) begin fails++; $display("FAIL bypass_same_cycle: got valid %b id %0d, required 1 and 5", out_valid_o, out_id_o); end
      step();
      drive_in(1'b0, 4'd0); #1;
      vecs++; if (count_o !== 3'd0) begin fails++; $display("FAIL bypass_count: got %0d, required 0", count_o); end
`else
      vecs++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL nobypass_same_cycle: got %b, required 0", out_valid_o); end
      step();
      drive_in(1'b0, 4'd0); #1;
      vecs++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd5) begin fails++; $display("FAIL nobypass_next_cycle: got valid %b id %0d, required 1 and 5", out_valid_o, out_id_o); end
      step();
`endif
      vecs++; if (inflight_o !== 4'd1) begin fails++; $display("FAIL bypass_inflight: got %0d, required 1", inflight_o); end
      out_ready = 1'b0; done = 1'b1; step(); done = 1'b0;
   endtask

   initial begin
      vecs = 0; fails = 0; acc = 1'b0; next_id = 4'd0;
      test_reset();
      test_fill_drain();
      test_inflight_limit();
      test_flush();
      test_simultaneous();
      test_underflow();
      test_bypass();
      vecs++; if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule

// File: doc/rvv_issue_buffer.md
# rvv_issue_buffer

Parametrised instruction buffer between the scalar core's vector issue port and `vinsn_decoder`. It decouples the core from decoder back-pressure and enforces a configurable limit on vector instructions that are queued or in flight. Entries are dispatched in order. A scalar `flush_i` discards everything still queued, and a done counter tracks retirement of dispatched instructions.

## Interface
Parameters:
- `Depth`, default 4: number of queue entries. Must be a power of two, at least 2.
- `MaxInflight`, default 8: maximum of queued entries plus dispatched-but-not-done entries. Must be at least `Depth`.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `valid_i`  in  1  scalar core offers an instruction.
- `ready_o`  out  1  buffer accepts the instruction.
- `insn_i`  in  32  raw instruction.
- `insn_id_i`  in  `$bits(insn_id_t)`  instruction ID.
- `scalar_reg_i`  in  `$bits(xlen_t)`  scalar operand.
- `vec_context_i`  in  `$bits(vec_context_t)`  vtype/vl context.
- `flush_i`  in  1  discard all queued entries.
- `out_valid_o`  out  1  head entry valid toward the decoder.
- `out_ready_i`  in  1  decoder ready.
- `out_insn_o`  out  32  head instruction.
- `out_id_o`  out  `$bits(insn_id_t)`  head instruction ID.
- `out_scalar_o`  out  `$bits(xlen_t)`  head scalar operand.
- `out_context_o`  out  `$bits(vec_context_t)`  head context.
- `done_i`  in  1  one dispatched instruction retired (pulse; driven by the launcher's `done_o`).
- `count_o`  out  `$clog2(Depth)+1`  number of queued entries.
- `inflight_o`  out  `$clog2(MaxInflight)+1`  number of dispatched, not-done instructions.
- `err_o`  out  1  sticky: `done_i` was received while `inflight_o == 0`.

## Operation
- Storage: circular array of `{insn, id, scalar, context}`.
  - Read and write pointers are `$clog2(Depth)` bits wide and wrap naturally.
  - `count` is `$clog2(Depth)+1` bits wide.
- Enqueue handshake: `valid_i && ready_o`.
  - `ready_o = !flush_i && count < Depth && (count + inflight) < MaxInflight`.
- Dispatch handshake: `out_valid_o && out_ready_i`.
  - `out_valid_o = !flush_i && count != 0`, or the bypass condition (see Configuration).
  - Head outputs hold stable while `out_valid_o && !out_ready_i`.
- Inflight counter:
  - Dispatch alone: +1.
  - `done_i` alone: −1.
  - Dispatch and `done_i` in the same cycle: unchanged.
  - `done_i` with `inflight == 0`: counter stays 0 and `err_o` sets. `err_o` clears only on reset.
- Flush:
  - `flush_i` forces `ready_o = 0` and `out_valid_o = 0` combinationally.
  - On the next edge, `count` and both pointers go to 0.
  - `inflight` is unaffected; already-dispatched instructions still report `done_i`, and `done_i` is honoured during flush.
- Simultaneous enqueue and dispatch with `count == Depth`: enqueue is blocked because `ready_o == 0`. No same-cycle freed-slot reuse.
- Simultaneous enqueue and dispatch with `0 < count < Depth`: `count` is unchanged and both pointers advance.
- Reset, with `rst_ni` low:
  - `count_o = 0`, `inflight_o = 0`, `err_o = 0`, `out_valid_o = 0`.
  - Pointers are 0.
  - `ready_o = 0` while `flush_i` is high, otherwise 1.
  - `out_*` data outputs are don't-care.
  - Reset mid-operation discards all entries and clears `inflight`.

## Timing
- Without bypass, enqueue-to-`out_valid_o` latency is 1 cycle (registered storage).
- Sustained throughput is 1 instruction per cycle when `out_ready_i` stays high and the inflight limit is not reached.
- `count_o`, `inflight_o` and `err_o` are registered.
- `ready_o` and `out_valid_o` are combinational from registered state and `flush_i`.
  - With bypass, `out_valid_o` additionally depends on `valid_i`.
- A slot freed by `done_i` is visible in `ready_o` in the cycle after `done_i`.

## Configuration
- `RVV_ISSUE_BYPASS_EN` defined: when `count == 0`, `valid_i`, `out_ready_i` and `ready_o` are all true and `flush_i` is low:
  - `out_valid_o = 1`;
  - `out_*` data is driven from the inputs;
  - the entry is not written into storage;
  - `inflight` increments.
  This gives 0-cycle latency.
- Undefined: no bypass. Every instruction passes through storage, with a minimum latency of 1 cycle.

## Test plan
- Fill and drain, `Depth=4`, `out_ready_i=0`:
  - Enqueue IDs 0..3 → `count_o=4`, `ready_o=0`.
  - Raise `out_ready_i` → IDs dispatched 0,1,2,3 in order on consecutive cycles.
  - Then `inflight_o=4`.
- Inflight limit, `MaxInflight=8`:
  - Dispatch 8 instructions with no `done_i` → `ready_o=0`, `inflight_o=8`.
  - Pulse `done_i` once → `ready_o=1` in the next cycle.
- Flush:
  - Queue 3 entries with 2 inflight, then assert `flush_i` for 1 cycle → `out_valid_o=0` that cycle.
  - Next cycle: `count_o=0`, `inflight_o=2`.
  - A `done_i` issued during the flush cycle → `inflight_o=1`.
- Simultaneous events:
  - Dispatch plus `done_i` in the same cycle with `inflight=3` → `inflight_o` stays 3.
  - Enqueue plus dispatch with `count=2` → `count_o` stays 2.
  - Run for 10 cycles to exercise pointer wrap-around.
- Underflow: `done_i` with `inflight_o=0` → `err_o=1` next cycle and it stays set.
  - Assert reset → `err_o=0`, `count_o=0`, `out_valid_o=0`.
- Bypass, with `RVV_ISSUE_BYPASS_EN` defined: buffer empty, `valid_i=1`, `out_ready_i=1`, ID 5 →
  - `out_valid_o=1` and `out_id_o=5` in the same cycle;
  - `count_o` stays 0;
  - `inflight_o=1` next cycle.
  - With the macro undefined, ID 5 appears one cycle later.
